// File: rtl/io_input_ctrl.sv
// rtl/io_input_ctrl.sv - KEY/SW sync+debounce with W1C press events; define IO_IN_IRQ_EN for MASK register and irq
module io_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  key_raw,
  input  logic [9:0]  sw_raw,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int         NUM_IN = 14;
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);
  // Keys idle high at the pins, switches idle low.
  localparam logic [NUM_IN-1:0] SYNC_RESET = {10'b0, 4'hF};

  logic [NUM_IN-1:0] sync1;
  logic [NUM_IN-1:0] sync2;
  logic [NUM_IN-1:0] in_sync;
  logic [NUM_IN-1:0] stable;
  logic [NUM_IN-1:0] stable_next;
  logic [7:0]        cnt      [NUM_IN];
  logic [7:0]        cnt_next [NUM_IN];
  logic [3:0]        key_stable;
  logic [9:0]        sw_stable;
  logic [3:0]        key_rise;
  logic [3:0]        evt;
  logic [3:0]        mask;
  logic              is_io;
  logic              unused_bits;

  assign is_io = addr[8];

  // Debounce operates on active-high levels, so the key pins are inverted here.
  assign in_sync    = {sync2[13:4], ~sync2[3:0]};
  assign key_stable = stable[3:0];
  assign sw_stable  = stable[13:4];

  // Press event fires on the same edge the debounced key goes 0->1.
  assign key_rise = stable_next[3:0] & ~stable[3:0];

  // Two-flop synchronizer for all fourteen raw inputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= SYNC_RESET;
      sync2 <= SYNC_RESET;
    end else begin
      sync1 <= {sw_raw, key_raw};
      sync2 <= sync1;
    end
  end

  // Per-input debounce: count disagreement, flip stable when the count would hit the limit.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      stable_next[i] = stable[i];
      cnt_next[i]    = 8'd0;
      if (in_sync[i] != stable[i]) begin
        if (cnt[i] + 8'd1 == DB_LIMIT) begin
          stable_next[i] = in_sync[i];
          cnt_next[i]    = 8'd0;
        end else begin
          cnt_next[i] = cnt[i] + 8'd1;
        end
      end
    end
  end

  // Debounce state registers; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= 8'd0;
    end else begin
      stable <= stable_next;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= cnt_next[i];
    end
  end

  // Sticky event flags: write-1-to-clear, a same-cycle press wins over the clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      evt <= 4'b0;
    end else if (memwrite && is_io && addr[6]) begin
      evt <= (evt & ~writedata[3:0]) | key_rise;
    end else begin
      evt <= evt | key_rise;
    end
  end

`ifdef IO_IN_IRQ_EN
  // Interrupt mask register, plain read/write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask <= 4'b0;
    end else if (memwrite && is_io && addr[7]) begin
      mask <= writedata[3:0];
    end
  end

  assign irq = |(evt & mask);
`else
  assign mask = 4'b0;
  assign irq  = 1'b0;
`endif

  // Register read mux, KEY > SW > EVT > MASK when several selects are set.
  always_comb begin
    readdata = 32'd0;
    if (is_io) begin
      if (addr[4])      readdata = {28'b0, key_stable};
      else if (addr[5]) readdata = {22'b0, sw_stable};
      else if (addr[6]) readdata = {28'b0, evt};
      else if (addr[7]) readdata = {28'b0, mask};
    end
  end

  assign unused_bits = &{1'b0, addr[31:9], addr[3:0], writedata[31:4]};

endmodule

// File: tb/tb_io_input_ctrl.sv
// tb/tb_io_input_ctrl.sv - directed self-checking bench for io_input_ctrl
module tb_io_input_ctrl;

  logic        clk;
  logic        reset_n;
  logic [3:0]  key_raw;
  logic [9:0]  sw_raw;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        irq;

  int pass_cnt;
  int total_cnt;

  io_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_raw   (key_raw),
    .sw_raw    (sw_raw),
    .addr      (addr),
    .writedata (writedata),
    .memwrite  (memwrite),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, readdata, exp);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    key_raw   = 4'hF;
    sw_raw    = 10'h0;
    addr      = 32'h0;
    writedata = 32'h0;
    memwrite  = 1'b0;
    tick(2);
    reset_n = 1'b1;

    rd_check("rst_key",  32'h110, 32'h0);
    rd_check("rst_sw",   32'h120, 32'h0);
    rd_check("rst_evt",  32'h140, 32'h0);
    rd_check("rst_mask", 32'h180, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // KEY0 press: visible after 6 edges, not 5
    key_raw = 4'hE;
    tick(5);
    rd_check("key0_e5",  32'h110, 32'h0);
    rd_check("evt0_e5",  32'h140, 32'h0);
    tick(1);
    rd_check("key0_e6",  32'h110, 32'h1);
    rd_check("evt0_e6",  32'h140, 32'h1);

    // release sets nothing, flag stays sticky
    key_raw = 4'hF;
    tick(8);
    rd_check("key0_rel", 32'h110, 32'h0);
    rd_check("evt0_rel", 32'h140, 32'h1);
    store(32'h140, 32'h1);
    rd_check("evt0_clr", 32'h140, 32'h0);

    // 3-clock glitch on KEY1 is filtered
    key_raw = 4'hD;
    tick(3);
    key_raw = 4'hF;
    tick(10);
    rd_check("glitch_key", 32'h110, 32'h0);
    rd_check("glitch_evt", 32'h140, 32'h0);

    // switches
    sw_raw = 10'h2A5;
    tick(5);
    rd_check("sw_e5", 32'h120, 32'h0);
    tick(1);
    rd_check("sw_e6", 32'h120, 32'h2A5);
    rd_check("ram_addr", 32'h20, 32'h0);
    rd_check("no_sel", 32'h100, 32'h0);

    // priority KEY > SW > EVT
    sw_raw  = 10'h3FF;
    key_raw = 4'hD;
    tick(6);
    rd_check("prio_130", 32'h130, 32'h2);
    rd_check("prio_160", 32'h160, 32'h3FF);
    rd_check("evt1",     32'h140, 32'h2);
    store(32'h110, 32'hF);
    rd_check("key_ro",   32'h110, 32'h2);
    key_raw = 4'hF;
    tick(6);
    store(32'h140, 32'hF);
    rd_check("evt_clr_all", 32'h140, 32'h0);

`ifdef IO_IN_IRQ_EN
    store(32'h180, 32'h4);
    rd_check("mask_rd", 32'h180, 32'h4);
    check("irq_idle", {31'b0, irq}, 32'h0);
    key_raw = 4'hB;
    tick(6);
    check("irq_set", {31'b0, irq}, 32'h1);
    rd_check("evt2", 32'h140, 32'h4);
    store(32'h140, 32'h4);
    rd_check("evt2_clr", 32'h140, 32'h0);
    check("irq_clr", {31'b0, irq}, 32'h0);
    key_raw = 4'hF;
    tick(6);
`else
    store(32'h180, 32'hF);
    rd_check("nomask_rd", 32'h180, 32'h0);
    key_raw = 4'hE;
    tick(6);
    check("noirq", {31'b0, irq}, 32'h0);
    rd_check("noirq_evt", 32'h140, 32'h1);
    key_raw = 4'hF;
    tick(6);
    store(32'h140, 32'hF);
    rd_check("noirq_clr", 32'h140, 32'h0);
`endif

    // W1C on the press edge itself: set wins
    key_raw = 4'hB;
    tick(5);
    store(32'h140, 32'h4);
    rd_check("set_wins", 32'h140, 32'h4);
`ifdef IO_IN_IRQ_EN
    check("set_wins_irq", {31'b0, irq}, 32'h1);
`endif
    key_raw = 4'hF;
    tick(6);
    store(32'h140, 32'hF);

    // reset mid-debounce requalifies in full
    key_raw = 4'h7;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    rd_check("rst2_mask", 32'h180, 32'h0);
    rd_check("rst2_sw",   32'h120, 32'h0);
    tick(5);
    rd_check("rst2_e5",   32'h110, 32'h0);
    tick(1);
    rd_check("rst2_e6",   32'h110, 32'h8);
    rd_check("rst2_evt",  32'h140, 32'h8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Memory-mapped input peripheral: the read side of the I/O region at 0x0000_0100, complementing the LEDR/HEX write registers. Synchronizes and debounces the four KEY buttons and ten SW switches, and captures key-press events in sticky write-1-to-clear flags. Returns its registers on the CPU data bus when the address falls in the I/O region. Sits beside the LED/HEX register logic in the top level; its `readdata` is muxed against RAM data on `addr[8]`.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive clocks a synchronized input must differ from its stable value before the stable value flips; legal range 1..255.
- `clk`  input  1  system clock (the divided CPU clock).
- `reset_n`  input  1  synchronous, active-low reset.
- `key_raw`  input  4  raw KEY pins, active-low (0 = pressed).
- `sw_raw`  input  10  raw SW pins, 1 = up.
- `addr`  input  32  CPU data address.
- `writedata`  input  32  CPU store data.
- `memwrite`  input  1  CPU store strobe.
- `readdata`  output  32  register read data; combinational from `addr` and internal registers.
- `irq`  output  1  level interrupt: OR of masked event flags.

## Operation
- Select: `isIO = addr[8]`. One-hot register select within I/O:
  - `addr[4]` (0x110) KEY: read `{28'b0, key_stable}`, 1 = pressed (inverted from pins). Read-only.
  - `addr[5]` (0x120) SW: read `{22'b0, sw_stable}`. Read-only.
  - `addr[6]` (0x140) EVT: read `{28'b0, evt}`; a store writes 1 to clear: `evt &= ~writedata[3:0]`.
  - `addr[7]` (0x180) MASK: read/write `{28'b0, mask}`.
- Read priority if several bits are set: KEY > SW > EVT > MASK. `readdata` = 0 when `isIO` = 0 or when no select bit is set.
- Stores are ignored unless `memwrite & isIO` and the matching select bit is set. Stores to KEY/SW have no effect.
- Input path for each of the 14 inputs:
  - Two-flop synchronizer, then per-input debounce counter (8 bits).
  - Counter clears whenever the synchronized value equals the stable value.
  - Otherwise the counter increments. When the increment would reach `DEBOUNCE_CYCLES`, the stable value takes the synchronized value and the counter clears.
- Event: `evt[i]` sets on the clock where `key_stable[i]` goes 0->1 (press). Release sets nothing.
- Set and W1C on the same bit in the same cycle: set wins, so the flag stays 1.
- `irq = |(evt & mask)`.

## Timing
- Reset when `reset_n` = 0 at a rising `clk`:
  - KEY synchronizer flops = 1 (released); SW synchronizer flops = 0.
  - `key_stable` = 0, `sw_stable` = 0, counters = 0, `evt` = 0, `mask` = 0, so `irq` = 0.
- Reset mid-debounce discards the partial count. After reset, an input held active re-qualifies in full: 2 + `DEBOUNCE_CYCLES` edges.
- Latency: raw change before edge 0 becomes visible in the stable value, `evt`, `readdata` and `irq` after edge 2 + `DEBOUNCE_CYCLES` (edge 6 with the default).
- Glitch shorter than `DEBOUNCE_CYCLES` synchronized clocks: no stable change, no event.
- MASK/EVT store takes effect at the store's clock edge. A read in the following cycle returns the new value.
- `DEBOUNCE_CYCLES` = 1: stable follows the synchronizer output with 1 clock of lag.

## Configuration
- `IO_IN_IRQ_EN` defined: MASK register and `irq` behave as above.
- Undefined: MASK register not implemented; it reads 0 and stores to it are ignored. `irq` is tied to 0. EVT and all other behaviour are unchanged.

## Test plan
- Reset: drive `reset_n` = 0 for 2 clocks with `key_raw` = 4'hF, `sw_raw` = 0 -> `readdata` = 0 at 0x110/0x120/0x140/0x180 and `irq` = 0.
- Debounce: `key_raw` = 4'hE from edge 0 -> 0x110 reads 0x1 and 0x140 reads 0x1 after edge 6, not after edge 5. A 3-clock low pulse on `key_raw[1]` -> KEY and EVT remain 0.
- Switch: `sw_raw` = 10'h2A5, stable -> 0x120 reads 0x0000_02A5 after 6 edges. `addr` = 0x0000_0020 (RAM) -> `readdata` = 0.
- W1C/IRQ (with `IO_IN_IRQ_EN`): store 0x4 to 0x180, press KEY2 -> `irq` = 1. Store 0x4 to 0x140 -> EVT = 0 and `irq` = 0 on the next cycle. Store 0x4 on the press edge itself -> EVT[2] stays 1.
- Priority: `addr` = 0x0000_0130 with KEY = 0x2 and SW = 0x3FF -> `readdata` = 0x2.
- Without `IO_IN_IRQ_EN`: store 0xF to 0x180, press KEY0 -> 0x180 reads 0, `irq` = 0, 0x140 reads 0x1.
